// File: rtl/vram_arbiter_pkg.sv
// Shared definitions for the video RAM arbiter.
// Holds the default video RAM geometry (also used by the vga block and the
// RAM wrapper), the arbiter FSM state encoding and the access-owner tag.
package vram_arbiter_pkg;

  localparam int VRAM_ADDR_W = 13;  // 8 KB video RAM
  localparam int VRAM_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no access in flight, grant point
    ST_RUN  = 2'd1,  // RAM samples the registered address / write
    ST_CAP  = 2'd2   // read data is on ram_rdata, deliver and re-arbitrate
  } state_e;

  typedef enum logic {
    OWN_VGA = 1'b0,
    OWN_CPU = 1'b1
  } owner_e;

endpackage

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one synchronous single-port video RAM between the VGA
// byte fetch (absolute priority, bounded latency) and the CPU bus.
//
// Ports
//   clk        pixel clock, rising edge
//   reset      asynchronous, active-low
//   vga_slot   1-cycle strobe: fetch the byte at vga_addr
//   vga_addr   VGA fetch address, sampled with vga_slot
//   vga_data   last fetched VGA byte (held)
//   vga_valid  1-cycle pulse when vga_data updates
//   vga_ovr    sticky: a pending VGA fetch was replaced before being served
//   cpu_req    CPU request level, with cpu_we/cpu_addr/cpu_wdata stable until ack
//   cpu_ack    1-cycle pulse: CPU access done (cpu_rdata valid for reads)
//   cpu_rdata  last CPU read data (held)
//   ram_addr / ram_we / ram_wdata   registered RAM controls
//   ram_rdata  RAM read data, valid one edge after the RAM samples ram_addr
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vga_slot,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_data,
  output logic              vga_valid,
  output logic              vga_ovr,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              op_we_q, op_we_d;
  logic              vga_pend_q, vga_pend_d;
  logic [ADDR_W-1:0] vga_addr_q, vga_addr_d;
  logic              vga_ovr_q, vga_ovr_d;
  logic [DATA_W-1:0] vga_data_q, vga_data_d;
  logic              vga_valid_q, vga_valid_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

  logic grant_point;
  logic vga_want;
  logic cpu_blocked;
  logic grant_vga;
  logic grant_cpu;

  // State register (reset also drops ram_we at once, abandoning any access)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_VGA;
      op_we_q     <= 1'b0;
      vga_pend_q  <= 1'b0;
      vga_addr_q  <= '0;
      vga_ovr_q   <= 1'b0;
      vga_data_q  <= '0;
      vga_valid_q <= 1'b0;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      op_we_q     <= op_we_d;
      vga_pend_q  <= vga_pend_d;
      vga_addr_q  <= vga_addr_d;
      vga_ovr_q   <= vga_ovr_d;
      vga_data_q  <= vga_data_d;
      vga_valid_q <= vga_valid_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  // Arbitration and next state
  always_comb begin
    grant_point = (state_q == ST_IDLE) || (state_q == ST_CAP);
    vga_want    = vga_pend_q || vga_slot;
    // The CPU is held off on the edge that issues its ack and during the ack
    // cycle, so a CPU that releases cpu_req on ack gets exactly one access.
    cpu_blocked = cpu_ack_q || ((state_q == ST_CAP) && (owner_q == OWN_CPU));
    grant_vga   = grant_point && vga_want;
    grant_cpu   = grant_point && !vga_want && cpu_req && !cpu_blocked;

    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE, ST_CAP: state_d = (grant_vga || grant_cpu) ? ST_RUN : ST_IDLE;
      ST_RUN:          state_d = ST_CAP;
      default:         state_d = ST_IDLE;
    endcase
  end

  // Datapath and outputs
  always_comb begin
    owner_d     = owner_q;
    op_we_d     = op_we_q;
    vga_pend_d  = vga_pend_q;
    vga_addr_d  = vga_addr_q;
    vga_ovr_d   = vga_ovr_q;
    vga_data_d  = vga_data_q;
    vga_valid_d = 1'b0;
    cpu_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;          // write enable lives for one cycle only
    ram_wdata_d = ram_wdata_q;

    if (vga_slot) begin
      vga_pend_d = 1'b1;
      vga_addr_d = vga_addr;
      // The older latched address is replaced before it was ever served.
      if (vga_pend_q) vga_ovr_d = 1'b1;
    end

    if (state_q == ST_CAP) begin
      if (owner_q == OWN_VGA) begin
        vga_data_d  = ram_rdata;
        vga_valid_d = 1'b1;
      end else begin
        cpu_ack_d = 1'b1;
        if (!op_we_q) cpu_rdata_d = ram_rdata;
      end
    end

    if (grant_vga) begin
      owner_d    = OWN_VGA;
      ram_addr_d = vga_slot ? vga_addr : vga_addr_q;
      vga_pend_d = 1'b0;
    end else if (grant_cpu) begin
      owner_d     = OWN_CPU;
      op_we_d     = cpu_we;
      ram_addr_d  = cpu_addr;
      ram_we_d    = cpu_we;
      ram_wdata_d = cpu_wdata;
    end
  end

  assign vga_data  = vga_data_q;
  assign vga_valid = vga_valid_q;
  assign vga_ovr   = vga_ovr_q;
  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: table-driven directed vectors, hand-written
// multi-cycle sequences, and a randomized phase scored against a memory model.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        vga_slot;
  logic [12:0] vga_addr;
  logic [7:0]  vga_data;
  logic        vga_valid;
  logic        vga_ovr;
  logic        cpu_req;
  logic        cpu_we;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic [12:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  int checks = 0;
  int failures = 0;
  int we_cnt = 0;
  logic loaded = 1'b0;
  logic vga_done;
  logic [7:0] mem [0:8191];
  logic [7:0] shadow [0:8191];

  vram_arbiter #(.ADDR_W(13), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .vga_slot(vga_slot), .vga_addr(vga_addr), .vga_data(vga_data),
    .vga_valid(vga_valid), .vga_ovr(vga_ovr),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input logic [12:0] a);
    logic [7:0] v;
    v = a[7:0] ^ {a[12:8], 3'b101};
    if (a == 13'h0040) v = 8'h3C;
    return v;
  endfunction

  // Synchronous single-port RAM: samples ram_addr at edge N, data at edge N+1.
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 8192; i++) mem[i] <= init_val(13'(i));
      loaded <= 1'b1;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  always @(negedge clk) if (ram_we === 1'b1) we_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_max(input string name, input int act, input int lim);
    checks++;
    if (act > lim) begin
      failures++;
      $display("FAIL %s: got %0d expected at most %0d", name, act, lim);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called right after a negedge. Returns at the negedge where cpu_ack is seen.
  task automatic cpu_access(input logic we, input logic [12:0] a, input logic [7:0] d,
                            input logic keep, output logic [7:0] rd, output int lat,
                            output logic acked);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    lat = 0; acked = 1'b0;
    while (!acked && lat < 16) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (cpu_ack) acked = 1'b1;
    end
    rd = cpu_rdata;
    if (!keep) cpu_req = 1'b0;
    if (acked && we) shadow[a] = d;
  endtask

  task automatic vga_fetch(input logic [12:0] a, output logic [7:0] rd, output int lat,
                           output logic got);
    vga_slot = 1'b1; vga_addr = a;
    lat = 0; got = 1'b0;
    while (!got && lat < 8) begin
      @(posedge clk); lat++;
      @(negedge clk); vga_slot = 1'b0;
      if (vga_valid) got = 1'b1;
    end
    rd = vga_data;
  endtask

  typedef struct {
    bit          is_vga;
    bit          we;
    logic [12:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_data;
    int          exp_lat;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd, vd;
    int lat, base, n, a1, a2, vn, vcnt, wr_acks;
    logic ok, flag;

    tbl[0] = '{1'b0, 1'b1, 13'h0123, 8'hA5, 8'h00, 3};
    tbl[1] = '{1'b0, 1'b0, 13'h0123, 8'h00, 8'hA5, 3};
    tbl[2] = '{1'b1, 1'b0, 13'h0040, 8'h00, 8'h3C, 3};
    tbl[3] = '{1'b0, 1'b1, 13'h1FFF, 8'hFF, 8'h00, 3};
    tbl[4] = '{1'b0, 1'b0, 13'h1FFF, 8'h00, 8'hFF, 3};
    tbl[5] = '{1'b0, 1'b1, 13'h0000, 8'h5A, 8'h00, 3};
    tbl[6] = '{1'b0, 1'b0, 13'h0000, 8'h00, 8'h5A, 3};
    tbl[7] = '{1'b1, 1'b0, 13'h1FFF, 8'h00, 8'hFF, 3};
    tbl[8] = '{1'b1, 1'b0, 13'h0000, 8'h00, 8'h5A, 3};
    tbl[9] = '{1'b1, 1'b0, 13'h0123, 8'h00, 8'hA5, 3};

    for (int i = 0; i < 8192; i++) shadow[i] = init_val(13'(i));

    reset = 1'b0; vga_slot = 1'b0; vga_addr = '0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0040; cpu_wdata = '0;
    vga_done = 1'b0;
    idle(3);

    // Reset with a CPU request already waiting
    chk("rst vga_data", 32'(vga_data), 32'h0);
    chk("rst vga_valid", 32'(vga_valid), 32'h0);
    chk("rst vga_ovr", 32'(vga_ovr), 32'h0);
    chk("rst cpu_ack", 32'(cpu_ack), 32'h0);
    chk("rst cpu_rdata", 32'(cpu_rdata), 32'h0);
    chk("rst ram_addr", 32'(ram_addr), 32'h0);
    chk("rst ram_we", 32'(ram_we), 32'h0);
    chk("rst ram_wdata", 32'(ram_wdata), 32'h0);
    reset = 1'b1;
    cpu_access(1'b0, 13'h0040, 8'h00, 1'b0, rd, lat, ok);
    chk("rst first ack latency", 32'(lat), 32'd3);
    chk("rst first read data", 32'(rd), 32'h3C);
    idle(2);

    // Directed vectors
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].is_vga) begin
        vga_fetch(tbl[i].addr, rd, lat, ok);
        chk($sformatf("tbl%0d vga latency", i), 32'(lat), 32'(tbl[i].exp_lat));
        chk($sformatf("tbl%0d vga data", i), 32'(rd), 32'(tbl[i].exp_data));
        chk($sformatf("tbl%0d vga_ovr", i), 32'(vga_ovr), 32'h0);
        idle(1);
        chk($sformatf("tbl%0d vga_valid pulse", i), 32'(vga_valid), 32'h0);
      end else begin
        base = we_cnt;
        cpu_access(tbl[i].we, tbl[i].addr, tbl[i].wdata, 1'b0, rd, lat, ok);
        chk($sformatf("tbl%0d cpu latency", i), 32'(lat), 32'(tbl[i].exp_lat));
        if (!tbl[i].we) chk($sformatf("tbl%0d cpu rdata", i), 32'(rd), 32'(tbl[i].exp_data));
        idle(1);
        chk($sformatf("tbl%0d ram_we pulses", i), 32'(we_cnt - base), 32'(tbl[i].we));
        chk($sformatf("tbl%0d cpu_ack pulse", i), 32'(cpu_ack), 32'h0);
      end
      idle(1);
    end

    // Reset in the middle of a CPU write
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h1100; cpu_wdata = 8'h77;
    @(posedge clk); #1;
    chk("midrst ram_we granted", 32'(ram_we), 32'h1);
    reset = 1'b0; #1;
    chk("midrst ram_we dropped", 32'(ram_we), 32'h0);
    chk("midrst cpu_ack", 32'(cpu_ack), 32'h0);
    cpu_req = 1'b0;
    idle(2);
    reset = 1'b1;
    flag = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (cpu_ack) flag = 1'b1;
    end
    chk("midrst no ack", 32'(flag), 32'h0);
    cpu_access(1'b0, 13'h1100, 8'h00, 1'b0, rd, lat, ok);
    chk("midrst write abandoned", 32'(rd), 32'(init_val(13'h1100)));
    idle(2);

    // VGA strobe one cycle after a CPU grant; a second CPU request waits
    base = we_cnt;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h1010; cpu_wdata = 8'h33;
    @(posedge clk);
    @(negedge clk);
    vga_slot = 1'b1; vga_addr = 13'h0300;
    n = 0; a1 = -1; a2 = -1; vn = -1; vd = '0;
    while (a2 < 0 && n < 12) begin
      @(posedge clk); n++;
      @(negedge clk); vga_slot = 1'b0;
      if (vga_valid) begin vn = n; vd = vga_data; end
      if (cpu_ack) begin
        if (a1 < 0) begin a1 = n; cpu_we = 1'b0; end
        else begin a2 = n; rd = cpu_rdata; cpu_req = 1'b0; end
      end
    end
    cpu_req = 1'b0;
    shadow[13'h1010] = 8'h33;
    chk("behind cpu first ack edge", 32'(a1), 32'd2);
    chk("behind cpu vga_valid edge", 32'(vn), 32'd4);
    chk("behind cpu vga_data", 32'(vd), 32'(init_val(13'h0300)));
    chk("behind cpu second ack edge", 32'(a2), 32'd6);
    chk("behind cpu read back", 32'(rd), 32'h33);
    chk("behind cpu ram_we pulses", 32'(we_cnt - base), 32'd1);
    chk("behind cpu vga_ovr", 32'(vga_ovr), 32'h0);
    idle(3);

    // Randomized traffic: VGA every 16 cycles then random spacing, CPU request held high
    base = we_cnt; wr_acks = 0; vcnt = 0;
    fork
      begin
        logic [7:0] vrd; int vlat; logic vgot; logic [12:0] va; int gap;
        for (int k = 0; k < 24; k++) begin
          gap = (k < 8) ? 16 : int'($urandom_range(5, 20));
          va = 13'h0200 + 13'($urandom_range(0, 13'h0DFF));
          vga_fetch(va, vrd, vlat, vgot);
          chk("rnd vga served", 32'(vgot), 32'h1);
          chk_max("rnd vga latency", vlat, 4);
          chk("rnd vga data", 32'(vrd), 32'(init_val(va)));
          if (vgot) vcnt++;
          if (gap > vlat) idle(gap - vlat);
        end
        vga_done = 1'b1;
      end
      begin
        logic [7:0] crd; int clat; logic cok, cwe; logic [12:0] ca; logic [7:0] cd, cexp;
        while (!vga_done) begin
          cwe = 1'($urandom_range(0, 1));
          ca = 13'h1000 + 13'($urandom_range(0, 255));
          cd = 8'($urandom);
          cexp = shadow[ca];
          cpu_access(cwe, ca, cd, 1'b1, crd, clat, cok);
          chk("rnd cpu acked", 32'(cok), 32'h1);
          chk_max("rnd cpu latency", clat, 6);
          if (cok && cwe) wr_acks++;
          if (!cwe) chk("rnd cpu rdata", 32'(crd), 32'(cexp));
        end
        cpu_req = 1'b0;
      end
    join
    idle(4);
    chk("rnd vga fetch count", 32'(vcnt), 32'd24);
    chk("rnd one ram_we per write", 32'(we_cnt - base), 32'(wr_acks));
    chk("rnd vga_ovr clear", 32'(vga_ovr), 32'h0);

    // Two VGA strobes before the pending one is served
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h1010;
    @(posedge clk);
    @(negedge clk);
    vga_slot = 1'b1; vga_addr = 13'h0500;
    @(posedge clk);
    @(negedge clk);
    chk("ovr after first strobe", 32'(vga_ovr), 32'h0);
    vga_addr = 13'h0600;
    @(posedge clk);
    @(negedge clk);
    vga_slot = 1'b0;
    chk("ovr after second strobe", 32'(vga_ovr), 32'h1);
    chk("ovr cpu ack", 32'(cpu_ack), 32'h1);
    chk("ovr cpu rdata", 32'(cpu_rdata), 32'(shadow[13'h1010]));
    cpu_req = 1'b0;
    vcnt = 0; vd = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (vga_valid) begin vcnt++; vd = vga_data; end
    end
    chk("ovr single fetch", 32'(vcnt), 32'd1);
    chk("ovr second address fetched", 32'(vd), 32'(init_val(13'h0600)));
    idle(5);
    chk("ovr sticky", 32'(vga_ovr), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
